// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: memory-op one-hot bit positions and the trace entry layout.
package cpu_pkg;
  localparam int MEMOP_LB  = 0;
  localparam int MEMOP_LBU = 1;
  localparam int MEMOP_LH  = 2;
  localparam int MEMOP_LHU = 3;
  localparam int MEMOP_LW  = 4;
  localparam int MEMOP_SB  = 5;
  localparam int MEMOP_SH  = 6;
  localparam int MEMOP_SW  = 7;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } trace_entry_t;
endpackage

// File: rtl/wb_trace_fifo.sv
// Synchronous FIFO of trace entries with full/empty flags; head is read straight from storage.
module wb_trace_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  trace_entry_t push_data,
  input  logic         pop,
  output trace_entry_t head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  trace_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/wb_stage.sv
// Write-back stage: load alignment/extension, result select, RF write, forwarding, retire count.
// Optional buffered trace port with backpressure is built when WB_TRACE_EN is defined.
module wb_stage
  import cpu_pkg::*;
#(
  parameter int TRACE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] result,
  input  logic [31:0] pc,
  input  logic [7:0]  mem_op,
  input  logic        res_from_mem,
  input  logic        res_from_csr,
  input  logic        gr_we,
  input  logic [4:0]  dest,
  input  logic [31:0] data_sram_rdata,
  input  logic [31:0] csr_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        fwd_valid,
  output logic [4:0]  fwd_dest,
  output logic [31:0] fwd_data,
  output logic [31:0] retired
`ifdef WB_TRACE_EN
  ,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [3:0]  trace_wen,
  output logic [4:0]  trace_wnum,
  output logic [31:0] trace_wdata
`endif
);
  if (TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("TRACE_DEPTH must be a power of two, at least 2");
  end

  logic        ready_go, retire, wr_ok;
  logic [31:0] rd, load_val, wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        unused_bits;

  assign unused_bits = ^{mem_op[MEMOP_SW:MEMOP_SB], pc};

  assign retire   = ~rst & in_valid & ready_go;
  assign in_ready = ~rst & (~in_valid | ready_go);

  assign ld_byte = 8'(rd >> {result[1:0], 3'b000});
  assign ld_half = 16'(rd >> {result[1], 4'b0000});

  always_comb begin
    load_val = rd;
    if (mem_op[MEMOP_LB])       load_val = {{24{ld_byte[7]}}, ld_byte};
    else if (mem_op[MEMOP_LBU]) load_val = {24'h0, ld_byte};
    else if (mem_op[MEMOP_LH])  load_val = {{16{ld_half[15]}}, ld_half};
    else if (mem_op[MEMOP_LHU]) load_val = {16'h0, ld_half};
  end

  assign wdata = res_from_mem ? load_val : (res_from_csr ? csr_rdata : result);

  // Stores have gr_we low, so they retire without a GPR write.
  assign wr_ok     = gr_we & (dest != 5'd0);
  assign rf_we     = retire & wr_ok;
  assign rf_waddr  = dest;
  assign rf_wdata  = wdata;
  assign fwd_valid = ~rst & in_valid & wr_ok;
  assign fwd_dest  = dest;
  assign fwd_data  = wdata;

  always_ff @(posedge clk) begin
    if (rst)         retired <= '0;
    else if (retire) retired <= retired + 32'd1;
  end

`ifdef WB_TRACE_EN
  logic         fifo_full, fifo_empty, held;
  logic [31:0]  hold_reg;
  trace_entry_t push_e, head_e;

  assign ready_go = ~fifo_full;
  assign rd       = held ? hold_reg : data_sram_rdata;

  // SRAM data is only valid on the first WB cycle, so capture it when a stall starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      held     <= 1'b0;
      hold_reg <= '0;
    end else if (retire) begin
      held     <= 1'b0;
    end else if (in_valid & ~ready_go & ~held) begin
      hold_reg <= data_sram_rdata;
      held     <= 1'b1;
    end
  end

  assign push_e = '{pc: pc, wen: {4{rf_we}}, wnum: dest, wdata: wdata};

  wb_trace_fifo #(.DEPTH(TRACE_DEPTH)) u_trace_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (retire),
    .push_data (push_e),
    .pop       (trace_valid & trace_ready),
    .head      (head_e),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign trace_valid = ~fifo_empty;
  assign trace_pc    = fifo_empty ? '0 : head_e.pc;
  assign trace_wen   = fifo_empty ? '0 : head_e.wen;
  assign trace_wnum  = fifo_empty ? '0 : head_e.wnum;
  assign trace_wdata = fifo_empty ? '0 : head_e.wdata;
`else
  assign ready_go = 1'b1;
  assign rd       = data_sram_rdata;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed load/select cases, random vectors against a
// behavioural model, retire-counter wrap, reset, and (with WB_TRACE_EN) trace backpressure.
module tb_wb_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready;
  logic [31:0] result, pc, data_sram_rdata, csr_rdata;
  logic [7:0]  mem_op;
  logic        res_from_mem, res_from_csr, gr_we;
  logic [4:0]  dest;
  logic        rf_we, fwd_valid;
  logic [4:0]  rf_waddr, fwd_dest;
  logic [31:0] rf_wdata, fwd_data, retired;
`ifdef WB_TRACE_EN
  logic        trace_valid, trace_ready;
  logic [31:0] trace_pc, trace_wdata;
  logic [3:0]  trace_wen;
  logic [4:0]  trace_wnum;
`endif

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_retired;

  always #5 clk = ~clk;

  wb_stage #(.TRACE_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .pc(pc), .mem_op(mem_op),
    .res_from_mem(res_from_mem), .res_from_csr(res_from_csr),
    .gr_we(gr_we), .dest(dest), .data_sram_rdata(data_sram_rdata), .csr_rdata(csr_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .retired(retired)
`ifdef WB_TRACE_EN
    , .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
    .trace_wen(trace_wen), .trace_wnum(trace_wnum), .trace_wdata(trace_wdata)
`endif
  );

  // Reference load extraction written as plain arithmetic on byte/halfword values.
  function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] addr,
                                             input logic [31:0] data);
    logic [31:0] b, h;
    b = (data >> (8 * addr[1:0])) & 32'hFF;
    h = (data >> (16 * addr[1])) & 32'hFFFF;
    if (op[MEMOP_LB])  return (b >= 128)   ? b + 32'hFFFF_FF00 : b;
    if (op[MEMOP_LBU]) return b;
    if (op[MEMOP_LH])  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
    if (op[MEMOP_LHU]) return h;
    return data;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one instruction, checks the combinational WB outputs, then lets the edge commit it.
  task automatic step(input logic v, input logic [7:0] op, input logic [31:0] res,
                      input logic [31:0] rdat, input logic [31:0] csr, input logic from_mem,
                      input logic from_csr, input logic we, input logic [4:0] d,
                      input logic [31:0] ipc);
    logic [31:0] exp_w;
    logic        exp_wr;
    @(negedge clk);
    in_valid = v; mem_op = op; result = res; data_sram_rdata = rdat; csr_rdata = csr;
    res_from_mem = from_mem; res_from_csr = from_csr; gr_we = we; dest = d; pc = ipc;
    #1;
    exp_w  = from_mem ? model_load(op, res, rdat) : (from_csr ? csr : res);
    exp_wr = we && (d != 5'd0);
    chk("in_ready",  {31'h0, in_ready},  32'd1);
    chk("rf_we",     {31'h0, rf_we},     {31'h0, v && exp_wr});
    chk("rf_waddr",  {27'h0, rf_waddr},  {27'h0, d});
    chk("rf_wdata",  rf_wdata,           exp_w);
    chk("fwd_valid", {31'h0, fwd_valid}, {31'h0, v && exp_wr});
    chk("fwd_dest",  {27'h0, fwd_dest},  {27'h0, d});
    chk("fwd_data",  fwd_data,           exp_w);
    chk("retired",   retired,            exp_retired);
    if (v) exp_retired = exp_retired + 32'd1;
  endtask

  initial begin
    logic [7:0]  op;
    logic [31:0] r, dat, c;
    logic        fm, fc;
    rst = 1'b1; in_valid = 1'b0; mem_op = '0; result = '0; pc = '0; data_sram_rdata = '0;
    csr_rdata = '0; res_from_mem = 1'b0; res_from_csr = 1'b0; gr_we = 1'b0; dest = '0;
`ifdef WB_TRACE_EN
    trace_ready = 1'b1;
`endif
    exp_retired = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  {31'h0, in_ready},  32'd0);
    chk("rst_retired",   retired,            32'd0);
    chk("rst_rf_we",     {31'h0, rf_we},     32'd0);
    chk("rst_fwd_valid", {31'h0, fwd_valid}, 32'd0);
`ifdef WB_TRACE_EN
    chk("rst_trace_valid", {31'h0, trace_valid}, 32'd0);
    chk("rst_trace_pc",    trace_pc,             32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    step(1, 8'(1 << MEMOP_LB),  32'h1003, 32'h80FF_1234, 0, 1, 0, 1, 5'd3, 32'h100);
    step(1, 8'(1 << MEMOP_LBU), 32'h1003, 32'h80FF_1234, 0, 1, 0, 1, 5'd3, 32'h104);
    step(1, 8'(1 << MEMOP_LH),  32'h2002, 32'h9ABC_0001, 0, 1, 0, 1, 5'd4, 32'h108);
    step(1, 8'(1 << MEMOP_LHU), 32'h2002, 32'h9ABC_0001, 0, 1, 0, 1, 5'd4, 32'h10C);
    step(1, 8'(1 << MEMOP_LW),  32'h2000, 32'h9ABC_0001, 0, 1, 0, 1, 5'd5, 32'h110);
    step(1, 8'h00, 32'h1234_5678, 0, 32'hC5C5_0001, 0, 1, 1, 5'd6, 32'h114);
    step(1, 8'h00, 32'h0000_0042, 0, 0, 0, 0, 1, 5'd0, 32'h118);
    step(1, 8'(1 << MEMOP_SW),  32'h3000, 32'h5555_AAAA, 0, 0, 0, 0, 5'd7, 32'h11C);
    step(0, 8'h00, 32'h0000_0099, 0, 0, 0, 0, 1, 5'd8, 32'h120);

    for (int i = 0; i < 40; i++) begin
      op  = 8'(1 << $urandom_range(0, 7));
      r   = $urandom; dat = $urandom; c = $urandom;
      fm  = (op[MEMOP_SW:MEMOP_SB] == 3'b000) && ($urandom_range(0, 1) == 1);
      fc  = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 3) != 0, op, r, dat, c, fm, fc,
           op[MEMOP_SW:MEMOP_SB] == 3'b000, 5'($urandom_range(0, 31)), $urandom);
    end

    @(negedge clk);
    in_valid = 1'b0;
    force dut.retired = 32'hFFFF_FFFF;
    #1;
    release dut.retired;
    exp_retired = 32'hFFFF_FFFF;
    step(1, 8'h00, 32'h7, 0, 0, 0, 0, 1, 5'd9, 32'h200);
    step(0, 8'h00, 32'h7, 0, 0, 0, 0, 1, 5'd9, 32'h204);

`ifdef WB_TRACE_EN
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; trace_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_retired = '0;
    for (int i = 0; i < 4; i++)
      step(1, 8'h00, 32'(i + 1), 0, 0, 0, 0, 1, 5'(i + 1), 32'h400 + 32'(4 * i));
    @(negedge clk);
    in_valid = 1'b1; mem_op = 8'(1 << MEMOP_LW); res_from_mem = 1'b1; res_from_csr = 1'b0;
    gr_we = 1'b1; dest = 5'd10; result = 32'h3000; data_sram_rdata = 32'h1111_2222; pc = 32'h500;
    #1;
    chk("full_in_ready",  {31'h0, in_ready},    32'd0);
    chk("full_rf_we",     {31'h0, rf_we},       32'd0);
    chk("full_fwd_valid", {31'h0, fwd_valid},   32'd1);
    chk("full_trace_pc",  trace_pc,             32'h400);
    @(negedge clk);
    data_sram_rdata = 32'hDEAD_BEEF; trace_ready = 1'b1;
    #1;
    chk("stall_in_ready", {31'h0, in_ready}, 32'd0);
    chk("stall_fwd_data", fwd_data,          32'h1111_2222);
    chk("stall_retired",  retired,           32'd4);
    @(negedge clk);
    trace_ready = 1'b0;
    #1;
    chk("resume_in_ready", {31'h0, in_ready}, 32'd1);
    chk("resume_rf_we",    {31'h0, rf_we},    32'd1);
    chk("resume_rf_wdata", rf_wdata,          32'h1111_2222);
    chk("resume_trace_pc", trace_pc,          32'h404);
    @(negedge clk);
    in_valid = 1'b1; dest = 5'd11; result = 32'h3004; data_sram_rdata = 32'h7777_8888;
    #1;
    chk("refull_in_ready", {31'h0, in_ready}, 32'd0);
`endif

    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", {31'h0, in_ready}, 32'd0);
    chk("midrst_retired",  retired,           32'd0);
    chk("midrst_rf_we",    {31'h0, rf_we},    32'd0);
`ifdef WB_TRACE_EN
    chk("midrst_trace_valid", {31'h0, trace_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0; data_sram_rdata = 32'h0BAD_F00D;
    #1;
    chk("midrst_held_clear", rf_wdata, 32'h0BAD_F00D);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
